// File: rtl/prog_uart_pkg.sv
// Constants and types shared by the programming UART transmitter and receiver.
package prog_uart_pkg;

    localparam int unsigned UART_DATA_W  = 8;
    localparam int unsigned UART_MIN_CPB = 2;
    localparam int unsigned FRAME_BITS   = 10;
    localparam int unsigned CPB_W        = 16;
    localparam int unsigned BIT_IDX_W    = $clog2(UART_DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Bit periods below the minimum cannot form a distinguishable bit, so raise them.
    function automatic logic [CPB_W-1:0] clamp_cpb(input logic [CPB_W-1:0] cpb);
        return (cpb < CPB_W'(UART_MIN_CPB)) ? CPB_W'(UART_MIN_CPB) : cpb;
    endfunction

endpackage

// File: rtl/prog_uart_fifo.sv
// Single-clock FIFO; full/empty are derived from the occupancy count, pointers wrap naturally.
module prog_uart_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign do_push_c = push_i && !full_o;
    assign do_pop_c  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        if (do_push_c) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible through a valid count.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/prog_uart_tx.sv
// Programming-UART transmitter: drains the TX FIFO as 8N1 frames, LSB first,
// with the bit period latched from io_CLK_PER_BIT at the start of each frame.
module prog_uart_tx
    import prog_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CPB_W-1:0]       io_CLK_PER_BIT,
    input  logic [UART_DATA_W-1:0] io_tx_data_i,
    input  logic                   io_tx_valid_i,
    output logic                   io_tx_ready_o,
    output logic                   io_tx_o,
    output logic                   io_busy_o,
    output logic [CNT_W-1:0]       io_fifo_count_o
);

    uart_state_e            state_q, state_d;
    logic [CPB_W-1:0]       baud_q, baud_d;
    logic [CPB_W-1:0]       period_q, period_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   tx_q, tx_d;

    logic                   push_c;
    logic                   pop_c;
    logic [UART_DATA_W-1:0] fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [CPB_W-1:0]       period_new_c;

    assign push_c       = io_tx_valid_i && io_tx_ready_o;
    assign io_tx_ready_o = !fifo_full;
    assign period_new_c = clamp_cpb(io_CLK_PER_BIT);

    prog_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push_c),
        .data_i  (io_tx_data_i),
        .pop_i   (pop_c),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        period_d  = period_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop_c     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_c    = 1'b1;
                    shift_d  = fifo_head;
                    period_d = period_new_c;
                    baud_d   = period_new_c - CPB_W'(1);
                    tx_d     = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    baud_d    = period_q - CPB_W'(1);
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q - CPB_W'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = period_q - CPB_W'(1);
                    if (bit_idx_q == BIT_IDX_W'(UART_DATA_W - 1)) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q - CPB_W'(1);
                end
            end
            STOP: begin
                // Chain straight into the next start bit so queued bytes leave with no idle gap.
                if (baud_q == '0) begin
                    if (!fifo_empty) begin
                        pop_c    = 1'b1;
                        shift_d  = fifo_head;
                        period_d = period_new_c;
                        baud_d   = period_new_c - CPB_W'(1);
                        tx_d     = 1'b0;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - CPB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            period_q  <= CPB_W'(UART_MIN_CPB);
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            period_q  <= period_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign io_tx_o         = tx_q;
    assign io_busy_o       = (state_q != IDLE) || (fifo_count != '0);
    assign io_fifo_count_o = fifo_count;

endmodule

// File: tb/tb_prog_uart_tx.sv
// Directed bench for prog_uart_tx: frame vectors from a table plus multi-cycle corner sequences.
module tb_prog_uart_tx;
    import prog_uart_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [15:0] cpb;
        logic [7:0]  data;
        int          p;
        logic [9:0]  line;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   cpb = 16'd4;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_valid = 1'b0;
    logic          ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] count;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    prog_uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .io_CLK_PER_BIT  (cpb),
        .io_tx_data_i    (tx_data),
        .io_tx_valid_i   (tx_valid),
        .io_tx_ready_o   (ready),
        .io_tx_o         (tx),
        .io_busy_o       (busy),
        .io_fifo_count_o (count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic push_byte(input logic [7:0] d, output int acc_cyc, output bit ok);
        tx_data  = d;
        tx_valid = 1'b1;
        ok       = 1'b0;
        acc_cyc  = -1;
        for (int i = 0; i < 400; i++) begin
            if (ready === 1'b1) begin
                @(posedge clock);
                @(negedge clock);
                acc_cyc = cyc;
                ok      = 1'b1;
                break;
            end
            @(negedge clock);
        end
        tx_valid = 1'b0;
    endtask

    // Waits for a start bit, samples each of the 10 bit slots mid-bit and
    // returns at the negedge of the last stop-bit cycle.
    task automatic get_frame(input int p, input int budget, output logic [9:0] line,
                             output int start, output bit busy_ok, output bit ok);
        int cur;
        ok      = 1'b0;
        line    = '0;
        start   = -1;
        busy_ok = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        start = cyc;
        cur   = 0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        for (int b = 0; b < 10; b++) begin
            while (cur < b * p + p / 2) begin
                @(negedge clock);
                cur++;
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
            line[b] = tx;
        end
        while (cur < 10 * p - 1) begin
            @(negedge clock);
            cur++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    initial begin
        vec_t        vecs [6];
        logic [7:0]  bytes [10];
        logic [9:0]  line;
        int          acc, acc0, st, st_prev, peak, lows;
        bit          ok, bok, ok2;

        // line[i] is the level of bit slot i: start, d0..d7, stop.
        vecs[0] = '{cpb: 16'd4, data: 8'hA5, p: 4, line: 10'b1101001010};
        vecs[1] = '{cpb: 16'd0, data: 8'h3A, p: 2, line: 10'b1001110100};
        vecs[2] = '{cpb: 16'd1, data: 8'hC3, p: 2, line: 10'b1110000110};
        vecs[3] = '{cpb: 16'd2, data: 8'h01, p: 2, line: 10'b1000000010};
        vecs[4] = '{cpb: 16'd5, data: 8'h80, p: 5, line: 10'b1100000000};
        vecs[5] = '{cpb: 16'd7, data: 8'h6B, p: 7, line: 10'b1011010110};

        repeat (3) @(negedge clock);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single frames, one table row at a time.
        for (int i = 0; i < 6; i++) begin
            cpb = vecs[i].cpb;
            push_byte(vecs[i].data, acc, ok);
            check($sformatf("v%0d_accept", i), 32'(ok), 32'd1);
            check($sformatf("v%0d_count_after_push", i), 32'(count), 32'd1);
            get_frame(vecs[i].p, 20, line, st, bok, ok);
            check($sformatf("v%0d_frame_seen", i), 32'(ok), 32'd1);
            check($sformatf("v%0d_latency", i), 32'(st), 32'(acc + 1));
            check($sformatf("v%0d_line", i), 32'(line), 32'(vecs[i].line));
            check($sformatf("v%0d_busy_in_frame", i), 32'(bok), 32'd1);
            @(negedge clock);
            check($sformatf("v%0d_idle_tx", i), 32'(tx), 32'd1);
            check($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
        end

        // Back-to-back frames with no idle gap.
        cpb  = 16'd3;
        peak = 0;
        fork
            begin
                push_byte(8'h00, acc, ok);
                push_byte(8'hFF, acc, ok);
                push_byte(8'h55, acc, ok);
            end
            begin
                get_frame(3, 20, line, st, bok, ok);
                check("b2b_f0_line", 32'(line), 32'(10'b1000000000));
                st_prev = st;
                get_frame(3, 1, line, st, bok, ok);
                check("b2b_f1_line", 32'(line), 32'(10'b1111111110));
                check("b2b_f1_gap", 32'(st - st_prev), 32'd30);
                st_prev = st;
                get_frame(3, 1, line, st, bok, ok2);
                check("b2b_f2_line", 32'(line), 32'(10'b1010101010));
                check("b2b_f2_gap", 32'(st - st_prev), 32'd30);
                check("b2b_count_at_last_start", 32'(count), 32'd0);
            end
            begin
                for (int i = 0; i < 95; i++) begin
                    @(negedge clock);
                    if (int'(count) > peak) peak = int'(count);
                end
            end
        join
        check("b2b_count_peak", 32'(peak), 32'd2);
        @(negedge clock);
        check("b2b_idle_busy", 32'(busy), 32'd0);

        // Full FIFO back-pressure, ordering preserved across 10 frames.
        cpb = 16'd16;
        for (int k = 0; k < 10; k++) bytes[k] = 8'(8'h5A ^ (k * 23));
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    push_byte(bytes[k], acc, ok);
                    check($sformatf("full_accept%0d", k), 32'(ok), 32'd1);
                    if (k == 8) begin
                        check("full_ready_low", 32'(ready), 32'd0);
                        check("full_count", 32'(count), 32'd8);
                    end
                end
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    get_frame(16, (k == 0) ? 20 : 1, line, st, bok, ok);
                    check($sformatf("full_frame%0d", k), 32'(line), 32'({1'b1, bytes[k], 1'b0}));
                end
            end
        join
        @(negedge clock);
        check("full_drained_busy", 32'(busy), 32'd0);

        // Bit-period change mid-frame takes effect only on the next frame.
        cpb = 16'd4;
        fork
            begin
                push_byte(8'h12, acc, ok);
                push_byte(8'h34, acc, ok);
                repeat (10) @(negedge clock);
                cpb = 16'd8;
            end
            begin
                get_frame(4, 20, line, st, bok, ok);
                check("rt_f0_line", 32'(line), 32'(10'b1000100100));
                st_prev = st;
                get_frame(8, 1, line, st, bok, ok);
                check("rt_f1_line", 32'(line), 32'(10'b1001101000));
                check("rt_f0_len", 32'(st - st_prev), 32'd40);
            end
        join
        @(negedge clock);
        check("rt_f1_len_idle", 32'(tx), 32'd1);
        check("rt_f1_len_busy", 32'(busy), 32'd0);

        // Reset during data bit 3 aborts the frame and flushes the queue.
        cpb = 16'd4;
        push_byte(8'h3C, acc, ok);
        push_byte(8'h81, acc, ok);
        check("rst_frame_started", 32'(tx), 32'd0);
        repeat (17) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        reset = 1'b0;
        lows  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("rst_no_resume", 32'(lows), 32'd0);

        // Push coinciding with the STOP->START pop keeps count and order.
        cpb = 16'd4;
        fork
            begin
                push_byte(8'h11, acc0, ok);
                push_byte(8'h22, acc, ok);
                for (int i = 0; i < 100 && cyc != acc0 + 40; i++) @(negedge clock);
                check("sim_reach_edge", 32'(cyc), 32'(acc0 + 40));
                check("sim_count_before", 32'(count), 32'd1);
                push_byte(8'h33, acc, ok);
                check("sim_count_after", 32'(count), 32'd1);
                check("sim_new_start", 32'(tx), 32'd0);
            end
            begin
                get_frame(4, 20, line, st, bok, ok);
                check("sim_f0", 32'(line), 32'(10'b1000100010));
                get_frame(4, 1, line, st, bok, ok);
                check("sim_f1", 32'(line), 32'(10'b1001000100));
                get_frame(4, 1, line, st, bok, ok);
                check("sim_f2", 32'(line), 32'(10'b1001100110));
            end
        join
        @(negedge clock);
        check("sim_idle_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
